// File: rtl/ahbl_slv_mem_if.sv
// ahbl_slv_mem_if: AHB-Lite bus signals between one master and one memory responder
interface ahbl_slv_mem_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hwrite;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;
  modport master (
    output hsel, haddr, htrans, hsize, hburst, hprot, hwrite, hwdata,
    input  hready, hreadyout, hresp, hrdata
  );
  modport slave (
    input  hsel, haddr, htrans, hsize, hburst, hprot, hwrite, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahbl_slv_mem.sv
// ahbl_slv_mem: AHB-Lite responder backed by a word-addressed register-file memory
module ahbl_slv_mem #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input logic           hclk,
  input logic           hreset,
  ahbl_slv_mem_if.slave b
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WL = WAIT_STATES > 0 ? 4'(WAIT_STATES - 1) : 4'd0;
  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;
  state_t        state, nxt;
  logic [3:0]    cnt, cnt_n;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] a_idx;
  logic [3:0]    a_be, be;
  logic          a_wr, dp, acc, ill, wr;
  logic          unused;
  assign unused = ^{b.hburst, b.hprot, b.htrans[0]};
  assign acc = b.hsel && b.hready && b.htrans[1];
  assign ill = b.haddr >= 32'(DEPTH * 4) || b.hsize > 3'd2 ||
               (b.hsize == 3'd1 && b.haddr[0]) ||
               (b.hsize == 3'd2 && b.haddr[1:0] != 2'd0);
  assign be = b.hsize == 3'd0 ? 4'b0001 << b.haddr[1:0] :
              b.hsize == 3'd1 ? (b.haddr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign b.hreadyout = state == IDLE || state == ERR2;
  assign b.hresp     = state == ERR1 || state == ERR2;
  // combinational read so a write committed at the same edge is already visible
  assign b.hrdata    = dp && !a_wr ? mem[a_idx] : 32'd0;
  assign wr          = dp && a_wr && state == IDLE;
  always_comb begin
    cnt_n = state == WAIT ? cnt - 4'd1 : WL;
    nxt   = state == ERR1 ? ERR2 :
            state == WAIT ? (cnt == 4'd0 ? IDLE : WAIT) :
            !acc ? IDLE : ill ? ERR1 : WAIT_STATES > 0 ? WAIT : IDLE;
  end
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state <= IDLE;
      cnt   <= '0;
      dp    <= 1'b0;
      a_idx <= '0;
      a_be  <= '0;
      a_wr  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt_n;
      if (wr)
        for (int i = 0; i < 4; i++)
          if (a_be[i]) mem[a_idx][8*i +: 8] <= b.hwdata[8*i +: 8];
      if (b.hreadyout) begin
        dp <= acc && !ill;
        if (acc) begin
          a_idx <= b.haddr[AW+1:2];
          a_be  <= be;
          a_wr  <= b.hwrite;
        end
      end
    end
  end
endmodule

// File: tb/tb_ahbl_slv_mem.sv
// tb_ahbl_slv_mem: directed checks of the AHB-Lite memory responder (zero and three wait states)
module tb_ahbl_slv_mem;
  logic        hclk = 1'b0;
  logic        hreset = 1'b1;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] ea [4];
  logic [2:0]  ez [4];
  logic        ew [4];
  always #5 hclk = ~hclk;
  ahbl_slv_mem_if b0();
  ahbl_slv_mem_if b3();
  assign b0.hready = b0.hreadyout;
  assign b3.hready = b3.hreadyout;
  ahbl_slv_mem #(.DEPTH(256), .WAIT_STATES(0)) d0 (.hclk(hclk), .hreset(hreset), .b(b0));
  ahbl_slv_mem #(.DEPTH(256), .WAIT_STATES(3)) d3 (.hclk(hclk), .hreset(hreset), .b(b3));
  task automatic tick;
    @(posedge hclk);
    #1;
  endtask
  task automatic ap0(input logic s, input logic [1:0] t, input logic [31:0] a, input logic [2:0] z, input logic w);
    b0.hsel = s; b0.htrans = t; b0.haddr = a; b0.hsize = z; b0.hwrite = w;
  endtask
  task automatic ap3(input logic s, input logic [1:0] t, input logic [31:0] a, input logic [2:0] z, input logic w);
    b3.hsel = s; b3.htrans = t; b3.haddr = a; b3.hsize = z; b3.hwrite = w;
  endtask
  task automatic wr0(input logic [31:0] a, input logic [2:0] z, input logic [31:0] d);
    ap0(1, 2'b10, a, z, 1);
    tick;
    b0.hwdata = d;
    ap0(0, 2'b00, 0, 0, 0);
    tick;
  endtask
  task automatic rd0(input logic [31:0] a, output logic [31:0] d);
    ap0(1, 2'b10, a, 3'd2, 0);
    tick;
    ap0(0, 2'b00, 0, 0, 0);
    d = b0.hrdata;
    tick;
  endtask
  task automatic test_reset;
    logic [31:0] d;
    ap3(1, 2'b10, 32'h10, 3'd2, 0);
    tick;
    ap3(0, 2'b00, 0, 0, 0);
    checks++; if (b3.hreadyout !== 1'b0) begin errors++; $display("FAIL pre_reset_wait got %b want 0", b3.hreadyout); end
    hreset = 1'b1;
    tick;
    tick;
    checks++; if (b3.hreadyout !== 1'b1) begin errors++; $display("FAIL reset_ready3 got %b want 1", b3.hreadyout); end
    checks++; if (b3.hresp !== 1'b0) begin errors++; $display("FAIL reset_resp3 got %b want 0", b3.hresp); end
    checks++; if (b3.hrdata !== 32'h0) begin errors++; $display("FAIL reset_rdata3 got %h want 00000000", b3.hrdata); end
    checks++; if (b0.hreadyout !== 1'b1 || b0.hresp !== 1'b0) begin errors++; $display("FAIL reset_out0 got %b%b want 10", b0.hreadyout, b0.hresp); end
    hreset = 1'b0;
    rd0(32'h10, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_read got %h want 00000000", d); end
  endtask
  task automatic test_word;
    ap0(1, 2'b10, 32'h20, 3'd2, 1);
    tick;
    b0.hwdata = 32'hDEADBEEF;
    ap0(1, 2'b10, 32'h20, 3'd2, 0);
    checks++; if (b0.hreadyout !== 1'b1) begin errors++; $display("FAIL word_wr_ready got %b want 1", b0.hreadyout); end
    tick;
    ap0(0, 2'b00, 0, 0, 0);
    checks++; if (b0.hreadyout !== 1'b1) begin errors++; $display("FAIL word_rd_ready got %b want 1", b0.hreadyout); end
    checks++; if (b0.hrdata !== 32'hDEADBEEF) begin errors++; $display("FAIL word_raw got %h want deadbeef", b0.hrdata); end
    tick;
    checks++; if (b0.hrdata !== 32'h0) begin errors++; $display("FAIL word_idle_rdata got %h want 00000000", b0.hrdata); end
  endtask
  task automatic test_lanes;
    logic [31:0] d;
    wr0(32'h40, 3'd2, 32'h11223344);
    wr0(32'h41, 3'd0, 32'h0000AA00);
    wr0(32'h42, 3'd1, 32'hBBBB0000);
    rd0(32'h40, d);
    checks++; if (d !== 32'hBBBBAA44) begin errors++; $display("FAIL lanes got %h want bbbbaa44", d); end
    rd0(32'h20, d);
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL lanes_other got %h want deadbeef", d); end
  endtask
  task automatic test_wait;
    int n;
    ap3(1, 2'b10, 32'h8, 3'd2, 1);
    tick;
    b3.hwdata = 32'h12345678;
    ap3(1, 2'b10, 32'h8, 3'd2, 0);
    n = 0;
    while (!b3.hreadyout && n < 20) begin n++; tick; end
    checks++; if (n !== 3) begin errors++; $display("FAIL wait_wr_lows got %0d want 3", n); end
    tick;
    ap3(0, 2'b00, 0, 0, 0);
    checks++; if (b3.hrdata !== 32'h12345678) begin errors++; $display("FAIL wait_rd_early got %h want 12345678", b3.hrdata); end
    n = 0;
    while (!b3.hreadyout && n < 20) begin n++; tick; end
    checks++; if (n !== 3) begin errors++; $display("FAIL wait_rd_lows got %0d want 3", n); end
    checks++; if (b3.hrdata !== 32'h12345678 || b3.hresp !== 1'b0) begin errors++; $display("FAIL wait_rd_final got %h/%b want 12345678/0", b3.hrdata, b3.hresp); end
    tick;
    checks++; if (b3.hreadyout !== 1'b1 || b3.hrdata !== 32'h0) begin errors++; $display("FAIL wait_after got %b/%h want 1/00000000", b3.hreadyout, b3.hrdata); end
  endtask
  task automatic test_errors;
    logic [31:0] d;
    ea[0] = 32'h400; ez[0] = 3'd2; ew[0] = 1'b0;
    ea[1] = 32'h002; ez[1] = 3'd2; ew[1] = 1'b1;
    ea[2] = 32'h040; ez[2] = 3'd3; ew[2] = 1'b1;
    ea[3] = 32'h040; ez[3] = 3'd2; ew[3] = 1'b0;
    ap0(1, 2'b10, ea[0], ez[0], ew[0]);
    tick;
    for (int i = 0; i < 3; i++) begin
      b0.hwdata = 32'hFFFFFFFF;
      ap0(1, 2'b10, ea[i+1], ez[i+1], ew[i+1]);
      checks++; if (b0.hreadyout !== 1'b0 || b0.hresp !== 1'b1) begin errors++; $display("FAIL err1_v%0d got %b%b want 01", i, b0.hreadyout, b0.hresp); end
      tick;
      checks++; if (b0.hreadyout !== 1'b1 || b0.hresp !== 1'b1) begin errors++; $display("FAIL err2_v%0d got %b%b want 11", i, b0.hreadyout, b0.hresp); end
      tick;
    end
    ap0(0, 2'b00, 0, 0, 0);
    checks++; if (b0.hreadyout !== 1'b1 || b0.hresp !== 1'b0) begin errors++; $display("FAIL err_next_okay got %b%b want 10", b0.hreadyout, b0.hresp); end
    checks++; if (b0.hrdata !== 32'hBBBBAA44) begin errors++; $display("FAIL err_mem40 got %h want bbbbaa44", b0.hrdata); end
    tick;
    rd0(32'h0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL err_mem0 got %h want 00000000", d); end
  endtask
  task automatic test_idle;
    logic [31:0] d;
    b0.hwdata = 32'h0;
    ap0(1, 2'b01, 32'h40, 3'd2, 1);
    tick;
    checks++; if (b0.hreadyout !== 1'b1 || b0.hresp !== 1'b0) begin errors++; $display("FAIL busy_out got %b%b want 10", b0.hreadyout, b0.hresp); end
    ap0(0, 2'b10, 32'h40, 3'd2, 1);
    tick;
    checks++; if (b0.hreadyout !== 1'b1 || b0.hresp !== 1'b0) begin errors++; $display("FAIL unsel_out got %b%b want 10", b0.hreadyout, b0.hresp); end
    ap0(0, 2'b00, 0, 0, 0);
    tick;
    rd0(32'h40, d);
    checks++; if (d !== 32'hBBBBAA44) begin errors++; $display("FAIL idle_mem got %h want bbbbaa44", d); end
  endtask
  initial begin
    ap0(0, 2'b00, 0, 0, 0);
    ap3(0, 2'b00, 0, 0, 0);
    b0.hburst = 3'd0; b0.hprot = 4'd0; b0.hwdata = 32'h0;
    b3.hburst = 3'd0; b3.hprot = 4'd0; b3.hwdata = 32'h0;
    tick;
    tick;
    hreset = 1'b0;
    tick;
    test_reset;
    test_word;
    test_lanes;
    test_wait;
    test_errors;
    test_idle;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
